// File: rtl/rst_req_gen.sv
// -----------------------------------------------------------------------------
// rst_req_gen
//
// Reset-request initiator for a single destination clock domain. Drives an
// active-low reset into the destination's reset synchroniser and runs a 4-phase
// handshake against the destination's reset acknowledge:
//
//   IDLE --REQ--> HOLD --(min width && ack) or timeout--> RELEASE
//        RELEASE --(ack fell) or timeout--> IDLE (DONE pulse)
//
// The block powers up in HOLD, so the destination is held in reset while RST
// is high and a full power-on sequence runs as soon as RST is released.
//
// Ports:
//   CLK        single clock for the whole block
//   RST        asynchronous, active-high reset
//   REQ        soft-reset request, sampled on CLK (one-cycle pulse is enough)
//   RST_ACK    asynchronous acknowledge, 1 = destination is in reset
//   RST_OUT_N  registered active-low reset to the destination domain
//   BUSY       high while a reset sequence is in progress
//   DONE       one-cycle pulse when a sequence completes (also after timeout)
//   TIMEOUT    sticky: the last sequence timed out in HOLD or RELEASE
// -----------------------------------------------------------------------------
module rst_req_gen #(
   parameter int unsigned SYNC_STAGES       = 2,
   parameter int unsigned MIN_ASSERT_CYCLES = 4,
   parameter int unsigned TIMEOUT_CYCLES    = 255,
   parameter int unsigned CNT_WIDTH         = 8
) (
   input  logic CLK,
   input  logic RST,
   input  logic REQ,
   input  logic RST_ACK,
   output logic RST_OUT_N,
   output logic BUSY,
   output logic DONE,
   output logic TIMEOUT
);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StHold    = 2'd1;
   localparam logic [1:0] StRelease = 2'd2;

   localparam logic [CNT_WIDTH-1:0] MinLast     = CNT_WIDTH'(MIN_ASSERT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CntMax      = '1;

   logic [1:0]             state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
   logic                   rst_out_n_q, rst_out_n_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   timeout_q, timeout_d;
   logic                   seen_q, seen_d;
   logic [SYNC_STAGES-1:0] ack_sync_q;
   logic                   ack_s;

   // Only the last synchroniser stage is ever looked at by the FSM.
   assign ack_s = ack_sync_q[SYNC_STAGES-1];

   // Saturating increment so a misconfigured timeout can never wrap.
   assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rst_out_n_d = rst_out_n_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      timeout_d   = timeout_q;
      seen_d      = seen_q;

      case (state_q)
         StIdle: begin
            if (REQ) begin
               state_d     = StHold;
               cnt_d       = '0;
               rst_out_n_d = 1'b0;
               busy_d      = 1'b1;
               timeout_d   = 1'b0;
            end
         end

         StHold: begin
            cnt_d = cnt_inc;
            if ((cnt_q >= MinLast) && ack_s) begin
               state_d     = StRelease;
               cnt_d       = '0;
               rst_out_n_d = 1'b1;
               seen_d      = 1'b1;
            end else if (cnt_q == TimeoutLast) begin
               state_d     = StRelease;
               cnt_d       = '0;
               rst_out_n_d = 1'b1;
               seen_d      = 1'b0;
               timeout_d   = 1'b1;
            end
         end

         StRelease: begin
            cnt_d = cnt_inc;
            // Release completes on a genuine fall of ack_s. After a HOLD
            // timeout the ack was never seen high, so a low ack_s is not a
            // fall; the sequence then waits for rise-then-fall or times out.
            if (ack_s) begin
               seen_d = 1'b1;
            end
            if (!ack_s && seen_q) begin
               state_d = StIdle;
               cnt_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (cnt_q == TimeoutLast) begin
               state_d   = StIdle;
               cnt_d     = '0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               timeout_d = 1'b1;
            end
         end

         default: begin
            // Unreachable encoding: recover by re-running a full sequence.
            state_d     = StHold;
            cnt_d       = '0;
            rst_out_n_d = 1'b0;
            busy_d      = 1'b1;
            seen_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= StHold;
         cnt_q       <= '0;
         rst_out_n_q <= 1'b0;
         busy_q      <= 1'b1;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         seen_q      <= 1'b0;
         ack_sync_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rst_out_n_q <= rst_out_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         seen_q      <= seen_d;
         ack_sync_q  <= {ack_sync_q[SYNC_STAGES-2:0], RST_ACK};
      end
   end

   assign RST_OUT_N = rst_out_n_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign TIMEOUT   = timeout_q;

endmodule
